// File: rtl/chess_pkg.sv
// Shared board-bus encodings and move types for the capture sequencer.
// Replaces the old cmd.vh macro set with typed enums and structs.
package chess_pkg;

    typedef enum logic [2:0] {
        SM_IDLE = 3'd0,
        SM_W    = 3'd1,
        SM_FP   = 3'd2,
        SM_FA   = 3'd3,
        SM_FV   = 3'd4
    } sm_t;

    typedef enum logic [1:0] {
        MM_NO_CHANGE = 2'd0,
        MM_DV_EAA    = 2'd1,
        MM_DA        = 2'd2,
        MM_EAV_EAA   = 2'd3
    } mm_t;

    typedef logic [5:0] square_t;

    typedef struct packed {
        square_t from;
        square_t to;
    } move_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FV,
        S_FA,
        S_PUSH,
        S_MASK_DA,
        S_MASK_DV,
        S_DONE
    } seq_state_t;

    localparam int         MOVE_W    = $bits(move_t);
    localparam logic [7:0] COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous move FIFO with valid/ready pop; a push into a full FIFO is accepted
// when a pop retires an entry on the same edge.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign pop_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop_valid && pop_ready;
    assign push_ok   = !full || do_pop;
    assign do_push   = push && push_ok;
    // Present zero rather than stale storage when nothing is queued.
    assign pop_data  = pop_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/capture_sequencer.sv
// MVV-LVA capture enumerator: owns the board bus while busy and queues {aggressor,victim} moves.
// Define CAPSEQ_STATS_EN to add board_cycles (busy cycles with an active board search).
module capture_sequencer
    import chess_pkg::*;
#(
    parameter int BOARD_LAT  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output sm_t         state_mode,
    output mm_t         mask_mode,
    output square_t     ss1,
    input  logic [6:0]  board_data,
    input  logic        board_illegal,
    output logic        move_valid,
    input  logic        move_ready,
    output logic [11:0] move_data,
    output logic [7:0]  move_count
`ifdef CAPSEQ_STATS_EN
    ,
    output logic [15:0] board_cycles
`endif
);
    localparam int                WAIT_W    = $clog2(BOARD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BOARD_LAT);

    seq_state_t        st;
    logic [WAIT_W-1:0] wait_cnt;
    square_t           victim;
    square_t           aggressor;
    logic              sample_now;
    logic              found;
    square_t           board_sq;
    logic              start_accept;
    logic              abort_run;
    logic              push_req;
    logic              push_ok;
    move_t             push_move;

    assign found        = board_data[6];
    assign board_sq     = board_data[5:0];
    assign sample_now   = (wait_cnt == WAIT_LAST);
    assign start_accept = (st == S_IDLE) && start && !abort;
    assign abort_run    = abort && (st != S_IDLE) && (st != S_DONE);
    assign push_req     = (st == S_PUSH) && !abort;
    assign push_move    = '{from: aggressor, to: victim};

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MOVE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_move),
        .push_ok   (push_ok),
        .pop_ready (move_ready),
        .pop_valid (move_valid),
        .pop_data  (move_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            state_mode <= SM_IDLE;
            mask_mode  <= MM_NO_CHANGE;
            ss1        <= '0;
            move_count <= '0;
        end else begin
            done      <= 1'b0;
            mask_mode <= MM_NO_CHANGE;
            if (push_req && push_ok) move_count <= sat_inc8(move_count);
            // Abort drops any mask pulse that would have followed this state.
            if (abort_run) begin
                st         <= S_DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
                state_mode <= SM_IDLE;
            end else begin
                unique case (st)
                    S_IDLE: if (start_accept) begin
                        st         <= S_CLR;
                        busy       <= 1'b1;
                        illegal    <= 1'b0;
                        move_count <= '0;
                        mask_mode  <= MM_EAV_EAA;
                    end
                    S_CLR: begin
                        st         <= S_FV;
                        state_mode <= SM_FV;
                        wait_cnt   <= '0;
                    end
                    S_FV: if (!sample_now) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (board_illegal || !found) begin
                        illegal    <= illegal | board_illegal;
                        st         <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_mode <= SM_IDLE;
                    end else begin
                        victim     <= board_sq;
                        ss1        <= board_sq;
                        st         <= S_FA;
                        state_mode <= SM_FA;
                        wait_cnt   <= '0;
                    end
                    S_FA: if (!sample_now) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (!found) begin
                        st         <= S_MASK_DV;
                        state_mode <= SM_IDLE;
                        mask_mode  <= MM_DV_EAA;
                    end else begin
                        aggressor  <= board_sq;
                        st         <= S_PUSH;
                        state_mode <= SM_IDLE;
                    end
                    S_PUSH: if (push_ok) begin
                        st        <= S_MASK_DA;
                        ss1       <= aggressor;
                        mask_mode <= MM_DA;
                    end
                    S_MASK_DA: begin
                        st         <= S_FA;
                        ss1        <= victim;
                        state_mode <= SM_FA;
                        wait_cnt   <= '0;
                    end
                    S_MASK_DV: begin
                        st         <= S_FV;
                        state_mode <= SM_FV;
                        wait_cnt   <= '0;
                    end
                    S_DONE: st <= S_IDLE;
                endcase
            end
        end
    end

`ifdef CAPSEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            board_cycles <= '0;
        end else if (busy && (state_mode != SM_IDLE) && (board_cycles != 16'hFFFF)) begin
            board_cycles <= board_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: abstract board model (victim list, per-victim aggressor lists, masks).
module tb_capture_sequencer;
    import chess_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, start, abort, busy, done, illegal, board_illegal;
    logic        move_valid, move_ready;
    sm_t         state_mode;
    mm_t         mask_mode;
    square_t     ss1;
    logic [6:0]  board_data;
    logic [11:0] move_data;
    logic [7:0]  move_count;
`ifdef CAPSEQ_STATS_EN
    logic [15:0] board_cycles;
`endif

    capture_sequencer #(.BOARD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .illegal       (illegal),
        .state_mode    (state_mode),
        .mask_mode     (mask_mode),
        .ss1           (ss1),
        .board_data    (board_data),
        .board_illegal (board_illegal),
        .move_valid    (move_valid),
        .move_ready    (move_ready),
        .move_data     (move_data),
        .move_count    (move_count)
`ifdef CAPSEQ_STATS_EN
        ,
        .board_cycles  (board_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Board contents: victims in MVV order, each with aggressors in LVA order.
    int   nv;
    int   vsq [8];
    bit   vking [8];
    int   nagg [8];
    int   agg [8][64];
    bit   vdis [8];
    bit   adis [64];
    logic [7:0] pipe [LAT];

    function automatic logic [7:0] board_resp(input sm_t sm, input square_t sel);
        if (sm == SM_FV)
            for (int i = 0; i < nv; i++)
                if (!vdis[i]) return {vking[i], 1'b1, 6'(vsq[i])};
        if (sm == SM_FA)
            for (int i = 0; i < nv; i++)
                if (6'(vsq[i]) == sel)
                    for (int j = 0; j < nagg[i]; j++)
                        if (!adis[agg[i][j]]) return {1'b0, 1'b1, 6'(agg[i][j])};
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= board_resp(state_mode, ss1);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        case (mask_mode)
            MM_EAV_EAA: begin vdis <= '{default: 1'b0}; adis <= '{default: 1'b0}; end
            MM_DA:      adis[ss1] <= 1'b1;
            MM_DV_EAA: begin
                adis <= '{default: 1'b0};
                for (int i = 0; i < nv; i++) if (6'(vsq[i]) == ss1) vdis[i] <= 1'b1;
            end
            default: ;
        endcase
    end

    assign board_data    = pipe[LAT-1][6:0];
    assign board_illegal = pipe[LAT-1][7];

    // Observers sample on the falling edge, away from DUT updates.
    mm_t         mask_log [$];
    logic [11:0] got_q [$];
    int          done_cnt;
    bit          fa_seen;

    always @(negedge clk) begin
        if (mask_mode != MM_NO_CHANGE) mask_log.push_back(mask_mode);
        if (done) done_cnt++;
        if (state_mode == SM_FA) fa_seen = 1'b1;
        if (move_valid && move_ready && !rst) got_q.push_back(move_data);
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [11:0] exp_q [$];
    bit          exp_ill;
    int          exp_masks;

    // Expected moves: every aggressor of every victim in board order, stopping at a king victim.
    task automatic model();
        exp_q.delete();
        exp_ill   = 1'b0;
        exp_masks = 1;
        for (int i = 0; i < nv; i++) begin
            if (vking[i]) begin exp_ill = 1'b1; break; end
            exp_masks += nagg[i] + 1;
            for (int j = 0; j < nagg[i]; j++) exp_q.push_back({6'(agg[i][j]), 6'(vsq[i])});
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        mask_log.delete();
        done_cnt = 0;
        fa_seen  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) move_ready = 1'($urandom_range(0, 1));
            step();
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic drain();
        move_ready = 1'b1;
        for (int i = 0; i < 100 && move_valid; i++) step();
        step();
    endtask

    task automatic set_single(input int v, input int a);
        nv = 1; vsq[0] = v; vking[0] = 1'b0; nagg[0] = 1; agg[0][0] = a;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; move_ready = 1'b0; nv = 0;
        step(LAT + 3);
        n_cmp++;
        if ({busy, done, illegal, mask_mode, ss1, move_valid, move_data, move_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b ill=%b mm=%0d ss1=%0d mv=%b md=%h cnt=%0d, want all 0",
                     busy, done, illegal, mask_mode, ss1, move_valid, move_data, move_count);
        end
        n_cmp++;
        if (state_mode !== SM_IDLE) begin n_fail++; $display("FAIL reset_state_mode: got %0d want %0d", state_mode, SM_IDLE); end
        rst = 1'b0;
        step(2);
        n_cmp++;
        if (busy !== 1'b0 || state_mode !== SM_IDLE) begin n_fail++; $display("FAIL reset_release_idle: busy=%b sm=%0d want 0/0", busy, state_mode); end
    endtask

    task automatic test_single_capture();
        int lat;
        bit ok;
        int bad;
        set_single(17, 8);
        model();
        clear_logs();
        move_ready = 1'b1;
        pulse_start();
        for (lat = 0; lat < 40 && !move_valid; lat++) step();
        n_cmp++;
        if (lat !== 2 * (LAT + 1) + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, 2 * (LAT + 1) + 2); end
        n_cmp++;
        if (move_data !== 12'h211) begin n_fail++; $display("FAIL single_move_data: got %h want 211", move_data); end
        wait_done(200, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got no done want done"); end
        drain();
        step(3);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (got_q.size() !== exp_q.size() || bad != 0) begin n_fail++; $display("FAIL single_moves: got %0d (%0d wrong) want %0d", got_q.size(), bad, exp_q.size()); end
        n_cmp++;
        if (move_count !== 8'd1 || illegal !== 1'b0) begin n_fail++; $display("FAIL single_count_ill: got cnt=%0d ill=%b want 1/0", move_count, illegal); end
        n_cmp++;
        if (mask_log.size() !== 3 || mask_log[0] !== MM_EAV_EAA || mask_log[1] !== MM_DA || mask_log[2] !== MM_DV_EAA) begin
            n_fail++;
            $display("FAIL single_masks: got %0d pulses want EAV_EAA,DA,DV_EAA", mask_log.size());
        end
        n_cmp++;
        if (done_cnt !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0d pulses busy=%b want 1/0", done_cnt, busy); end
    endtask

    task automatic test_two_attackers();
        bit ok;
        nv = 1; vsq[0] = 19; vking[0] = 1'b0; nagg[0] = 2; agg[0][0] = 2; agg[0][1] = 3;
        model();
        clear_logs();
        move_ready = 1'b1;
        pulse_start();
        wait_done(300, 1'b0, ok);
        drain();
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL two_done_timeout: got no done want done"); end
        n_cmp++;
        if (got_q.size() !== 2 || got_q[0] !== 12'h093 || got_q[1] !== 12'h0D3) begin
            n_fail++;
            $display("FAIL two_moves: got %0d moves first %h want 2 moves 093,0D3", got_q.size(), got_q.size() > 0 ? got_q[0] : 12'h0);
        end
        n_cmp++;
        if (move_count !== 8'd2) begin n_fail++; $display("FAIL two_count: got %0d want 2", move_count); end
    endtask

    task automatic test_illegal();
        bit ok;
        nv = 1; vsq[0] = 60; vking[0] = 1'b1; nagg[0] = 1; agg[0][0] = 4;
        clear_logs();
        move_ready = 1'b1;
        pulse_start();
        wait_done(100, 1'b0, ok);
        step(3);
        n_cmp++;
        if (!ok || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got done=%b ill=%b want 1/1", ok, illegal); end
        n_cmp++;
        if (got_q.size() !== 0 || move_count !== 8'd0 || fa_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_no_moves: got moves=%0d cnt=%0d fa=%b want 0/0/0", got_q.size(), move_count, fa_seen);
        end
        n_cmp++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL illegal_done_pulse: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        nv = 2;
        vsq[0] = 40; vking[0] = 1'b0; nagg[0] = 3; agg[0][0] = 1; agg[0][1] = 2; agg[0][2] = 3;
        vsq[1] = 41; vking[1] = 1'b0; nagg[1] = 3; agg[1][0] = 4; agg[1][1] = 5; agg[1][2] = 6;
        model();
        clear_logs();
        move_ready = 1'b0;
        pulse_start();
        step(60);
        n_cmp++;
        if (busy !== 1'b1 || move_count !== 8'd4 || state_mode !== SM_IDLE || done_cnt !== 0) begin
            n_fail++;
            $display("FAIL stall_full: got busy=%b cnt=%0d sm=%0d done=%0d want 1/4/0/0", busy, move_count, state_mode, done_cnt);
        end
        step(10);
        n_cmp++;
        if (move_count !== 8'd4 || move_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got cnt=%0d mv=%b want 4/1", move_count, move_valid); end
        move_ready = 1'b1;
        wait_done(300, 1'b0, ok);
        drain();
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (!ok || got_q.size() !== 6 || bad != 0) begin n_fail++; $display("FAIL stall_release: done=%b got %0d (%0d wrong) want 6", ok, got_q.size(), bad); end
        n_cmp++;
        if (move_count !== 8'd6) begin n_fail++; $display("FAIL stall_count: got %0d want 6", move_count); end
    endtask

    task automatic test_abort();
        set_single(17, 8);
        clear_logs();
        move_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 40 && state_mode != SM_FA; i++) step();
        step();
        n_cmp++;
        if (state_mode !== SM_FA) begin n_fail++; $display("FAIL abort_reach_fa: got sm=%0d want %0d", state_mode, SM_FA); end
        mask_log.delete();
        done_cnt = 0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || state_mode !== SM_IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next_cycle: got done=%b sm=%0d busy=%b want 1/0/0", done, state_mode, busy);
        end
        step(12);
        n_cmp++;
        if (mask_log.size() !== 0 || done_cnt !== 1 || got_q.size() !== 0 || move_count !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_quiet: got masks=%0d done=%0d moves=%0d cnt=%0d want 0/1/0/0", mask_log.size(), done_cnt, got_q.size(), move_count);
        end
        done_cnt = 0;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step(5);
        n_cmp++;
        if (busy !== 1'b0 || done_cnt !== 0 || state_mode !== SM_IDLE) begin
            n_fail++;
            $display("FAIL abort_beats_start: got busy=%b done=%0d sm=%0d want 0/0/0", busy, done_cnt, state_mode);
        end
    endtask

    task automatic test_reset_mid();
        set_single(17, 8);
        clear_logs();
        move_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 40 && mask_mode != MM_DA; i++) step();
        n_cmp++;
        if (mask_mode !== MM_DA || move_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_da: got mm=%0d mv=%b want %0d/1", mask_mode, move_valid, MM_DA); end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({busy, done, illegal, state_mode, mask_mode, ss1, move_valid, move_data, move_count} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: busy=%b sm=%0d mm=%0d ss1=%0d mv=%b cnt=%0d want all 0",
                     busy, state_mode, mask_mode, ss1, move_valid, move_count);
        end
        rst = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_saturate();
        bit ok;
        int bad;
        nv = 5;
        for (int i = 0; i < 5; i++) begin
            vsq[i] = 59 + i; vking[i] = 1'b0; nagg[i] = 59;
            for (int j = 0; j < 59; j++) agg[i][j] = j;
        end
        model();
        clear_logs();
        move_ready = 1'b1;
        pulse_start();
        wait_done(5000, 1'b0, ok);
        drain();
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (!ok || got_q.size() !== 295 || bad != 0) begin n_fail++; $display("FAIL sat_moves: done=%b got %0d (%0d wrong) want 295", ok, got_q.size(), bad); end
        n_cmp++;
        if (move_count !== 8'hFF) begin n_fail++; $display("FAIL sat_count: got %0d want 255", move_count); end
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        int s;
        logic [7:0] exp_cnt;
        for (int it = 0; it < 20; it++) begin
            nv = $urandom_range(1, 3);
            for (int i = 0; i < nv; i++) begin
                vsq[i]   = 40 + i * 5 + $urandom_range(0, 4);
                vking[i] = ($urandom_range(0, 5) == 0);
                nagg[i]  = $urandom_range(0, 5);
                s        = $urandom_range(0, 39);
                for (int j = 0; j < nagg[i]; j++) agg[i][j] = (s + j * 7) % 40;
            end
            model();
            clear_logs();
            pulse_start();
            wait_done(3000, 1'b1, ok);
            drain();
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
            exp_cnt = (exp_q.size() > 255) ? 8'hFF : 8'(exp_q.size());
            n_cmp++;
            if (!ok || got_q.size() !== exp_q.size() || bad != 0) begin
                n_fail++;
                $display("FAIL rand_moves[%0d]: done=%b got %0d (%0d wrong) want %0d", it, ok, got_q.size(), bad, exp_q.size());
            end
            n_cmp++;
            if (illegal !== exp_ill || move_count !== exp_cnt || mask_log.size() !== exp_masks) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got ill=%b cnt=%0d masks=%0d want %b/%0d/%0d",
                         it, illegal, move_count, mask_log.size(), exp_ill, exp_cnt, exp_masks);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_two_attackers();
        test_illegal();
        test_stall();
        test_abort();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at time %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
